traffic_countdown_display: RTL and testbench

- Downstream consumer of the two-direction traffic light controller's six lamp outputs.
- Decodes the current lamp phase and restarts a countdown on every phase change.
- Shows the remaining phase time in display units on a 2-digit, time-multiplexed, active-low 7-segment display.
- Also exports binary remaining time, phase code and an invalid-lamp flag for the board and the bench.

---
 rtl/traffic_pkg.sv | 41 ++++
 rtl/tcd_seg7_enc.sv | 26 ++
 rtl/traffic_countdown_display.sv | 153 +++++++++++++++
 tb/tb_traffic_countdown_display.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase codes, lamp patterns, default phase times and glyph constants
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_Y1Y2 = 3'd0,
    PH_R1Y2 = 3'd1,
    PH_G1R2 = 3'd2,
    PH_Y1R2 = 3'd3,
    PH_R1G2 = 3'd4,
    PH_ERR  = 3'd7
  } phase_e;

  // Lamp order {red1,yellow1,green1,red2,yellow2,green2}
  localparam logic [5:0] LAMP_Y1Y2 = 6'b010_010;
  localparam logic [5:0] LAMP_R1Y2 = 6'b100_010;
  localparam logic [5:0] LAMP_G1R2 = 6'b001_100;
  localparam logic [5:0] LAMP_Y1R2 = 6'b010_100;
  localparam logic [5:0] LAMP_R1G2 = 6'b100_001;

  localparam int DEF_UNIT_DIV  = 50;
  localparam int DEF_TIME_R1Y2 = 250;
  localparam int DEF_TIME_G1R2 = 2500;
  localparam int DEF_TIME_Y1R2 = 250;
  localparam int DEF_TIME_R1G2 = 2250;
  localparam int DEF_SCAN_DIV  = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;

  function automatic phase_e decode_lamps(input logic [5:0] lamps);
    case (lamps)
      LAMP_Y1Y2: return PH_Y1Y2;
      LAMP_R1Y2: return PH_R1Y2;
      LAMP_G1R2: return PH_G1R2;
      LAMP_Y1R2: return PH_Y1R2;
      LAMP_R1G2: return PH_R1G2;
      default:   return PH_ERR;
    endcase
  endfunction

endpackage

// File: rtl/tcd_seg7_enc.sv
// rtl/tcd_seg7_enc.sv - combinational BCD to active-low 7-segment encoder (bit0 = segment a)
module tcd_seg7_enc
  import traffic_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg_n = 7'h40;
      4'd1:    o_seg_n = 7'h79;
      4'd2:    o_seg_n = 7'h24;
      4'd3:    o_seg_n = 7'h30;
      4'd4:    o_seg_n = 7'h19;
      4'd5:    o_seg_n = 7'h12;
      4'd6:    o_seg_n = 7'h02;
      4'd7:    o_seg_n = 7'h78;
      4'd8:    o_seg_n = 7'h00;
      4'd9:    o_seg_n = 7'h10;
      default: o_seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/traffic_countdown_display.sv
// rtl/traffic_countdown_display.sv - lamp-phase countdown on a 2-digit multiplexed 7-segment display
// Optional: TRAFFIC_COUNTDOWN_LZ_BLANK_EN blanks a leading-zero tens digit while counting.
module traffic_countdown_display
  import traffic_pkg::*;
#(
  parameter int UNIT_DIV  = DEF_UNIT_DIV,
  parameter int TIME_R1Y2 = DEF_TIME_R1Y2,
  parameter int TIME_G1R2 = DEF_TIME_G1R2,
  parameter int TIME_Y1R2 = DEF_TIME_Y1R2,
  parameter int TIME_R1G2 = DEF_TIME_R1G2,
  parameter int SCAN_DIV  = DEF_SCAN_DIV
) (
  input  logic       clk,
  input  logic       ret,
  input  logic       red1,
  input  logic       yellow1,
  input  logic       green1,
  input  logic       red2,
  input  logic       yellow2,
  input  logic       green2,
  output logic [6:0] seg_n,
  output logic [1:0] dig_n,
  output logic [6:0] remain,
  output logic [2:0] phase,
  output logic       err
);

  if (UNIT_DIV < 1 || SCAN_DIV < 1) begin : g_bad_div
    $fatal(1, "UNIT_DIV and SCAN_DIV must be at least 1");
  end else begin : g_time_chk
    if ((TIME_R1Y2 % UNIT_DIV) != 0 || (TIME_G1R2 % UNIT_DIV) != 0 ||
        (TIME_Y1R2 % UNIT_DIV) != 0 || (TIME_R1G2 % UNIT_DIV) != 0) begin : g_bad_mod
      $fatal(1, "phase times must be multiples of UNIT_DIV");
    end
    if ((TIME_R1Y2 / UNIT_DIV) > 99 || (TIME_G1R2 / UNIT_DIV) > 99 ||
        (TIME_Y1R2 / UNIT_DIV) > 99 || (TIME_R1G2 / UNIT_DIV) > 99) begin : g_bad_range
      $fatal(1, "phase times exceed two display digits");
    end
  end

  localparam int SUB_W  = (UNIT_DIV > 1) ? $clog2(UNIT_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_W'(UNIT_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
  localparam logic [6:0] LOAD_R1Y2 = 7'(TIME_R1Y2 / UNIT_DIV);
  localparam logic [6:0] LOAD_G1R2 = 7'(TIME_G1R2 / UNIT_DIV);
  localparam logic [6:0] LOAD_Y1R2 = 7'(TIME_Y1R2 / UNIT_DIV);
  localparam logic [6:0] LOAD_R1G2 = 7'(TIME_R1G2 / UNIT_DIV);

  logic [5:0]        r_lq;
  phase_e            r_phase;
  logic              r_err;
  logic [6:0]        r_remain;
  logic [SUB_W-1:0]  r_sub_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic              r_sel;
  logic [1:0]        r_dig_n;
  logic [6:0]        r_seg_n;

  logic [5:0] w_lamps;
  phase_e     w_new_phase;
  logic [6:0] w_load;
  logic [3:0] w_tens;
  logic [3:0] w_units;
  logic [3:0] w_bcd;
  logic [6:0] w_enc_seg;
  logic [6:0] w_seg;

  assign w_lamps     = {red1, yellow1, green1, red2, yellow2, green2};
  assign w_new_phase = decode_lamps(w_lamps);

  always_comb begin
    w_load = 7'd0;
    case (w_new_phase)
      PH_R1Y2: w_load = LOAD_R1Y2;
      PH_G1R2: w_load = LOAD_G1R2;
      PH_Y1R2: w_load = LOAD_Y1R2;
      PH_R1G2: w_load = LOAD_R1G2;
      default: w_load = 7'd0;
    endcase
  end

  // A lamp change reloads the countdown even if a unit expires in the same cycle.
  always_ff @(posedge clk or posedge ret) begin
    if (ret) begin
      r_lq      <= LAMP_Y1Y2;
      r_phase   <= PH_Y1Y2;
      r_err     <= 1'b0;
      r_remain  <= 7'd0;
      r_sub_cnt <= '0;
    end else if (w_lamps != r_lq) begin
      r_lq      <= w_lamps;
      r_phase   <= w_new_phase;
      r_err     <= (w_new_phase == PH_ERR);
      r_remain  <= w_load;
      r_sub_cnt <= SUB_MAX;
    end else if (r_sub_cnt == '0) begin
      r_sub_cnt <= SUB_MAX;
      if (r_remain != 7'd0) r_remain <= r_remain - 7'd1;
    end else begin
      r_sub_cnt <= r_sub_cnt - SUB_W'(1);
    end
  end

  assign w_tens  = 4'(r_remain / 7'd10);
  assign w_units = 4'(r_remain % 7'd10);
  assign w_bcd   = r_sel ? w_tens : w_units;

  tcd_seg7_enc u_enc (
    .i_bcd   (w_bcd),
    .o_seg_n (w_enc_seg)
  );

  always_comb begin
    w_seg = w_enc_seg;
    if (r_phase == PH_Y1Y2) begin
      w_seg = SEG_BLANK;
    end else if (r_phase == PH_ERR) begin
      w_seg = SEG_E;
    end
`ifdef TRAFFIC_COUNTDOWN_LZ_BLANK_EN
    else if (r_sel && w_tens == 4'd0) begin
      w_seg = SEG_BLANK;
    end
`endif
  end

  // Segments and digit enable are registered together so both switch on the same edge.
  always_ff @(posedge clk or posedge ret) begin
    if (ret) begin
      r_scan_cnt <= '0;
      r_sel      <= 1'b0;
      r_dig_n    <= 2'b11;
      r_seg_n    <= SEG_BLANK;
    end else begin
      if (r_scan_cnt == SCAN_MAX) begin
        r_scan_cnt <= '0;
        r_sel      <= ~r_sel;
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
      r_dig_n <= r_sel ? 2'b01 : 2'b10;
      r_seg_n <= w_seg;
    end
  end

  assign seg_n  = r_seg_n;
  assign dig_n  = r_dig_n;
  assign remain = r_remain;
  assign phase  = r_phase;
  assign err    = r_err;

endmodule

// File: tb/tb_traffic_countdown_display.sv
// tb/tb_traffic_countdown_display.sv - scoreboard bench with a time-based reference model
module tb_traffic_countdown_display;

  localparam int UNIT_DIV = 50;
  localparam int SCAN_DIV = 16;
  localparam int T_R1Y2   = 250;
  localparam int T_G1R2   = 2500;
  localparam int T_Y1R2   = 250;
  localparam int T_R1G2   = 2250;

  typedef struct packed {
    logic [6:0] remain;
    logic [2:0] phase;
    logic       err;
    logic [1:0] dig_n;
    logic [6:0] seg_n;
  } exp_t;

  logic       clk = 1'b0;
  logic       ret = 1'b1;
  logic [5:0] lamps = 6'b010_010;
  logic [6:0] seg_n;
  logic [1:0] dig_n;
  logic [6:0] remain;
  logic [2:0] phase;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  exp_t sb_q[$];

  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [5:0] valid_pats [5] = '{6'b010_010, 6'b100_010, 6'b001_100, 6'b010_100, 6'b100_001};

  // Reference model: phase start is remembered, remaining time is derived from elapsed cycles.
  logic [5:0] m_lq;
  int         m_phase;
  int         m_load;
  int         m_elapsed;
  int         m_edges;

  traffic_countdown_display #(
    .UNIT_DIV  (UNIT_DIV),
    .TIME_R1Y2 (T_R1Y2),
    .TIME_G1R2 (T_G1R2),
    .TIME_Y1R2 (T_Y1R2),
    .TIME_R1G2 (T_R1G2),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk     (clk),
    .ret     (ret),
    .red1    (lamps[5]),
    .yellow1 (lamps[4]),
    .green1  (lamps[3]),
    .red2    (lamps[2]),
    .yellow2 (lamps[1]),
    .green2  (lamps[0]),
    .seg_n   (seg_n),
    .dig_n   (dig_n),
    .remain  (remain),
    .phase   (phase),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic int decode(input logic [5:0] l);
    case (l)
      6'b010_010: return 0;
      6'b100_010: return 1;
      6'b001_100: return 2;
      6'b010_100: return 3;
      6'b100_001: return 4;
      default:    return 7;
    endcase
  endfunction

  function automatic int load_of(input int ph);
    case (ph)
      1:       return T_R1Y2 / UNIT_DIV;
      2:       return T_G1R2 / UNIT_DIV;
      3:       return T_Y1R2 / UNIT_DIV;
      4:       return T_R1G2 / UNIT_DIV;
      default: return 0;
    endcase
  endfunction

  function automatic int cur_remain();
    int units_gone;
    units_gone = m_elapsed / UNIT_DIV;
    return (m_load > units_gone) ? m_load - units_gone : 0;
  endfunction

  function automatic logic [6:0] exp_seg(input int ph, input int rem, input int sel);
    int d;
    if (ph == 0) return 7'h7F;
    if (ph == 7) return 7'h06;
    d = (sel != 0) ? rem / 10 : rem % 10;
`ifdef TRAFFIC_COUNTDOWN_LZ_BLANK_EN
    if (sel != 0 && d == 0) return 7'h7F;
`endif
    return glyph[d];
  endfunction

  task automatic model_reset();
    m_lq      = 6'b010_010;
    m_phase   = 0;
    m_load    = 0;
    m_elapsed = 0;
    m_edges   = 0;
  endtask

  task automatic push_reset_exp();
    exp_t e;
    e = '{remain: 7'd0, phase: 3'd0, err: 1'b0, dig_n: 2'b11, seg_n: 7'h7F};
    sb_q.push_back(e);
  endtask

  task automatic model_step(input logic [5:0] l);
    exp_t e;
    int   prev_ph;
    int   prev_rem;
    int   sel;
    prev_ph  = m_phase;
    prev_rem = cur_remain();
    if (l != m_lq) begin
      m_lq      = l;
      m_phase   = decode(l);
      m_load    = load_of(m_phase);
      m_elapsed = 0;
    end else begin
      m_elapsed++;
    end
    m_edges++;
    sel      = ((m_edges - 1) / SCAN_DIV) % 2;
    e.remain = 7'(cur_remain());
    e.phase  = 3'(m_phase);
    e.err    = (m_phase == 7);
    e.dig_n  = (sel != 0) ? 2'b01 : 2'b10;
    e.seg_n  = exp_seg(prev_ph, prev_rem, sel);
    sb_q.push_back(e);
  endtask

  task automatic check_val(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic run(input logic [5:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      lamps = l;
      @(posedge clk);
      #1;
      model_step(l);
    end
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #2;
    ret = 1'b1;
    model_reset();
    push_reset_exp();
    #1;
    check_val("async_reset_remain", int'(remain), 0);
    check_val("async_reset_dig_n", int'(dig_n), 3);
    check_val("async_reset_seg_n", int'(seg_n), 'h7F);
    repeat (hold) begin
      @(posedge clk);
      #1;
      push_reset_exp();
    end
    ret = 1'b0;
  endtask

  // Monitor: one scoreboard comparison per cycle, away from the active edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      n_cycle++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = {remain, phase, err, dig_n, seg_n};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard cycle %0d: got remain=%0d phase=%0d err=%b dig_n=%b seg_n=%h, expected remain=%0d phase=%0d err=%b dig_n=%b seg_n=%h",
                   n_cycle, a.remain, a.phase, a.err, a.dig_n, a.seg_n,
                   e.remain, e.phase, e.err, e.dig_n, e.seg_n);
        end
      end
    end
  end

  initial begin
    logic [5:0] l;
    int         k;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      push_reset_exp();
    end
    ret = 1'b0;

    run(6'b010_010, 40);
    run(6'b100_010, 1);
    check_val("r1y2_phase", int'(phase), 1);
    check_val("r1y2_remain", int'(remain), 5);
    run(6'b100_010, 349);

    run(6'b001_100, 1);
    check_val("g1r2_remain", int'(remain), 50);
    run(6'b001_100, 59);

    run(6'b111_000, 1);
    check_val("err_flag", int'(err), 1);
    check_val("err_phase", int'(phase), 7);
    run(6'b111_000, 39);
    run(6'b010_100, 1);
    check_val("err_clear", int'(err), 0);
    run(6'b010_100, 299);

    run(6'b001_100, 1000);
    do_reset(2);
    run(6'b001_100, 1);
    check_val("reload_after_reset", int'(remain), 50);
    run(6'b001_100, 59);

    run(6'b010_100, 40);

    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 11) == 0) do_reset($urandom_range(0, 3));
      k = $urandom_range(0, 6);
      if (k < 5) l = valid_pats[k];
      else l = 6'($urandom);
      run(l, $urandom_range(1, 300));
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
